// File: rtl/seg7_pkg.sv
// Shared constants for the Segment7 display path: BCD digit geometry, board clock
// and the direction encoding used by the counter and the scanner.
package seg7_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam int          NDIG    = 3;
    localparam int unsigned CLK_HZ  = 40_000_000;
    localparam logic        DIR_UP  = 1'b0;
    localparam logic        DIR_DN  = 1'b1;

endpackage

// File: rtl/seg7_bcd_digit.sv
// One BCD decade of the Segment7 counter: registered 0-9 digit that steps up or down
// on step_en and reports carry/borrow to the next decade through cy.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic             dir,
    output logic [BCD_W-1:0] d,
    output logic             cy
);

    logic [BCD_W-1:0] d_r;
    logic [BCD_W-1:0] d_nxt_s;
    logic             at_end_s;

    // Next value and terminal detect; an out-of-range code falls back into 0-9 on the next step.
    always_comb begin
        at_end_s = 1'b0;
        d_nxt_s  = d_r;
        case (dir)
            DIR_UP: begin
                at_end_s = (d_r == BCD_MAX);
                if (d_r >= BCD_MAX) begin
                    d_nxt_s = BCD_W'(0);
                end else begin
                    d_nxt_s = d_r + BCD_W'(1);
                end
            end
            DIR_DN: begin
                at_end_s = (d_r == BCD_W'(0));
                if ((d_r == BCD_W'(0)) || (d_r > BCD_MAX)) begin
                    d_nxt_s = BCD_MAX;
                end else begin
                    d_nxt_s = d_r - BCD_W'(1);
                end
            end
            default: begin
                at_end_s = 1'b0;
                d_nxt_s  = d_r;
            end
        endcase
    end

    assign cy = step_en & at_end_s;

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= BCD_W'(0);
        end else if (step_en) begin
            d_r <= d_nxt_s;
        end else begin
            d_r <= d_r;
        end
    end

    assign d = d_r;

endmodule

// File: rtl/seg7_bcd_counter.sv
// Three-digit BCD up/down counter feeding the Segment7 scanner: prescaled tick,
// synchronized REVERSE switch, optional switch debounce under `SEG7_DEBOUNCE_EN`.
module seg7_bcd_counter
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV   = CLK_HZ,
    parameter int unsigned DEB_CYCLES = 400_000
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REVERSE,
    input  logic             ENABLE,
    output logic [BCD_W-1:0] DIG0,
    output logic [BCD_W-1:0] DIG1,
    output logic [BCD_W-1:0] DIG2,
    output logic             UPD,
    output logic             WRAP
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

    if ((TICK_DIV < 32'd2) || (TICK_DIV > 32'd67_108_864) || (DEB_CYCLES < 32'd1)) begin : g_param_check
        $error("seg7_bcd_counter: TICK_DIV must be 2..2^26 and DEB_CYCLES at least 1");
    end

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [1:0]       sync_r;
    logic             dir_r;
    logic             upd_r;
    logic             wrap_r;
    logic [NDIG:0]    cy_s;
    logic [BCD_W-1:0] dig_s [NDIG];

    // Prescaler: free-runs while enabled and simply pauses otherwise, so the phase survives ENABLE=0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_r <= PRE_W'(0);
        end else if (ENABLE) begin
            if (pre_r == PRE_LAST) begin
                pre_r <= PRE_W'(0);
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end else begin
            pre_r <= pre_r;
        end
    end

    assign tick_s = ENABLE & (pre_r == PRE_LAST);

    // Two-flop synchronizer for the asynchronous REVERSE switch.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], REVERSE};
        end
    end

`ifdef SEG7_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEB_CYCLES + 32'd1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);

    logic [DEB_W-1:0] deb_cnt_r;

    // Accept a new direction only after it has disagreed with dir for DEB_CYCLES cycles in a row.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            deb_cnt_r <= DEB_W'(0);
            dir_r     <= DIR_UP;
        end else if (sync_r[1] == dir_r) begin
            deb_cnt_r <= DEB_W'(0);
            dir_r     <= dir_r;
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r <= DEB_W'(0);
            dir_r     <= sync_r[1];
        end else begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            dir_r     <= dir_r;
        end
    end
`else
    // Direction register follows the synchronizer directly.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dir_r <= DIR_UP;
        end else begin
            dir_r <= sync_r[1];
        end
    end
`endif

    // Decade chain: ones steps on tick, each higher decade steps on the carry/borrow below it.
    assign cy_s[0] = tick_s;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit u_dig (
            .clk     (CLK),
            .rst_n   (RESET),
            .step_en (cy_s[i]),
            .dir     (dir_r),
            .d       (dig_s[i]),
            .cy      (cy_s[i+1])
        );
    end

    // UPD/WRAP registered in the same edge as the digits so all outputs change together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            upd_r  <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            upd_r  <= tick_s;
            wrap_r <= cy_s[NDIG];
        end
    end

    assign DIG0 = dig_s[0];
    assign DIG1 = dig_s[1];
    assign DIG2 = dig_s[2];
    assign UPD  = upd_r;
    assign WRAP = wrap_r;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Self-checking bench for seg7_bcd_counter against an integer-valued reference model.
`timescale 1ns/100ps
module tb_seg7_bcd_counter;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 8;

    logic       CLK     = 1'b0;
    logic       RESET   = 1'b1;
    logic       REVERSE = 1'b0;
    logic       ENABLE  = 1'b0;
    logic [3:0] DIG0, DIG1, DIG2;
    logic       UPD, WRAP;

    int total = 0;
    int bad   = 0;

    seg7_bcd_counter #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .CLK(CLK), .RESET(RESET), .REVERSE(REVERSE), .ENABLE(ENABLE),
        .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .UPD(UPD), .WRAP(WRAP)
    );

    always #12.5 CLK = ~CLK;

    // Reference model: the count is an integer 0..999, the prescaler a phase 0..TICK_DIV-1.
    int       m_val = 0, m_phase = 0, m_run = 0;
    bit       m_upd = 1'b0, m_wrap = 1'b0, m_dir = 1'b0;
    bit [1:0] m_hist = 2'b00;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_val <= 0; m_phase <= 0; m_run <= 0;
            m_upd <= 1'b0; m_wrap <= 1'b0; m_dir <= 1'b0; m_hist <= 2'b00;
        end else begin
            if (ENABLE && m_phase == TICK_DIV - 1) begin
                m_upd <= 1'b1;
                if (!m_dir) begin
                    m_val  <= (m_val + 1) % 1000;
                    m_wrap <= (m_val == 999);
                end else begin
                    m_val  <= (m_val + 999) % 1000;
                    m_wrap <= (m_val == 0);
                end
            end else begin
                m_upd  <= 1'b0;
                m_wrap <= 1'b0;
            end
            if (ENABLE) m_phase <= (m_phase + 1) % TICK_DIV;
            m_hist <= {m_hist[0], REVERSE};
`ifdef SEG7_DEBOUNCE_EN
            if (m_hist[1] == m_dir) m_run <= 0;
            else if (m_run + 1 == DEB_CYCLES) begin m_dir <= m_hist[1]; m_run <= 0; end
            else m_run <= m_run + 1;
`else
            m_dir <= m_hist[1];
`endif
        end
    end

    function automatic logic [11:0] bcd3(input int n);
        bcd3 = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [13:0] model_vec();
        model_vec = {bcd3(m_val), m_upd, m_wrap};
    endfunction

    task automatic test_reset();
        #1 RESET = 1'b0;
        ENABLE = 1'b1; REVERSE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== 14'd0) begin
                bad++; $display("FAIL reset_state got=%h exp=0000", {DIG2, DIG1, DIG0, UPD, WRAP});
            end
        end
    endtask

    task automatic test_count_up();
        RESET = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL count_up_model c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
            total++;
            if (DIG0 > 4'd9 || DIG1 > 4'd9 || DIG2 > 4'd9) begin
                bad++; $display("FAIL bcd_range got=%h%h%h exp=digits<=9", DIG2, DIG1, DIG0);
            end
            if (c <= 4) begin
                total++;
                if (UPD !== (c == 4)) begin
                    bad++; $display("FAIL first_upd c=%0d got=%b exp=%b", c, UPD, (c == 4));
                end
            end
        end
        total++;
        if ({DIG2, DIG1, DIG0} !== 12'h010) begin
            bad++; $display("FAIL count_to_010 got=%h exp=010", {DIG2, DIG1, DIG0});
        end
    endtask

    task automatic test_wrap_up();
        logic [13:0] exp_tab [3];
        int n;
        exp_tab = '{{12'h999, 1'b1, 1'b0}, {12'h000, 1'b1, 1'b1}, {12'h001, 1'b1, 1'b0}};
        n = 0;
        do begin
            @(negedge CLK); n++;
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL wrap_up_model n=%0d got=%h exp=%h", n, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
        end while (!(UPD === 1'b1 && {DIG2, DIG1, DIG0} === 12'h998) && n < 5000);
        total++;
        if ({DIG2, DIG1, DIG0, UPD, WRAP} !== {12'h998, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reach_998 got=%h exp=%h", {DIG2, DIG1, DIG0, UPD, WRAP}, {12'h998, 1'b1, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge CLK); n++; end while (UPD !== 1'b1 && n < 20);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== exp_tab[k]) begin
                bad++; $display("FAIL wrap_up_step%0d got=%h exp=%h", k, {DIG2, DIG1, DIG0, UPD, WRAP}, exp_tab[k]);
            end
        end
    endtask

    task automatic test_count_down();
        logic [13:0] exp_tab [3];
        int n;
        exp_tab = '{{12'h000, 1'b1, 1'b0}, {12'h999, 1'b1, 1'b1}, {12'h998, 1'b1, 1'b0}};
        ENABLE = 1'b0; REVERSE = 1'b1;
        repeat (12) @(negedge CLK);
        ENABLE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge CLK); n++; end while (UPD !== 1'b1 && n < 20);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== exp_tab[k]) begin
                bad++; $display("FAIL down_step%0d got=%h exp=%h", k, {DIG2, DIG1, DIG0, UPD, WRAP}, exp_tab[k]);
            end
        end
        n = 0;
        do begin
            @(negedge CLK); n++;
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL down_model n=%0d got=%h exp=%h", n, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
        end while (!(UPD === 1'b1 && {DIG2, DIG1, DIG0} === 12'h100) && n < 4000);
        n = 0;
        do begin @(negedge CLK); n++; end while (UPD !== 1'b1 && n < 20);
        total++;
        if ({DIG2, DIG1, DIG0, UPD, WRAP} !== {12'h099, 1'b1, 1'b0}) begin
            bad++; $display("FAIL borrow_100_099 got=%h exp=%h", {DIG2, DIG1, DIG0, UPD, WRAP}, {12'h099, 1'b1, 1'b0});
        end
    endtask

    task automatic test_enable_hold();
        logic [11:0] v;
        int n;
        n = 0;
        do begin @(negedge CLK); n++; end while (UPD !== 1'b1 && n < 20);
        @(negedge CLK);
        v = {DIG2, DIG1, DIG0};
        ENABLE = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD} !== {v, 1'b0}) begin
                bad++; $display("FAIL enable_hold c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD}, {v, 1'b0});
            end
        end
        ENABLE = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL enable_resume_model c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
            total++;
            if (UPD !== (c == 3)) begin
                bad++; $display("FAIL enable_resume_upd c=%0d got=%b exp=%b", c, UPD, (c == 3));
            end
        end
    endtask

    task automatic test_reverse_pulse();
        int v, n, step;
        int dl [3];
`ifdef SEG7_DEBOUNCE_EN
        dl = '{1, 2, 3};
`else
        dl = '{-1, -2, -1};
`endif
        ENABLE = 1'b0; REVERSE = 1'b0;
        repeat (12) @(negedge CLK);
        ENABLE = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (UPD !== 1'b1 && n < 20);
        v = int'(DIG2) * 100 + int'(DIG1) * 10 + int'(DIG0);
        REVERSE = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 5) REVERSE = 1'b0;
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL pulse_model c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
            if (c % 4 == 0) begin
                step = c / 4 - 1;
                total++;
                if ({DIG2, DIG1, DIG0, UPD} !== {bcd3((v + dl[step] + 1000) % 1000), 1'b1}) begin
                    bad++; $display("FAIL pulse_step%0d got=%h exp=%h", step, {DIG2, DIG1, DIG0, UPD}, {bcd3((v + dl[step] + 1000) % 1000), 1'b1});
                end
            end
        end
        v = int'(DIG2) * 100 + int'(DIG1) * 10 + int'(DIG0);
        ENABLE = 1'b0; REVERSE = 1'b1;
        repeat (12) @(negedge CLK);
        ENABLE = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c % 4 == 0) begin
                total++;
                if ({DIG2, DIG1, DIG0, UPD} !== {bcd3((v - c / 4 + 1000) % 1000), 1'b1}) begin
                    bad++; $display("FAIL hold_down c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD}, {bcd3((v - c / 4 + 1000) % 1000), 1'b1});
                end
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                REVERSE = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 20));
            end
            hold--;
            ENABLE = ($urandom_range(0, 7) != 0);
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== model_vec()) begin
                bad++; $display("FAIL random_model c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD, WRAP}, model_vec());
            end
            total++;
            if (DIG0 > 4'd9 || DIG1 > 4'd9 || DIG2 > 4'd9) begin
                bad++; $display("FAIL bcd_range got=%h%h%h exp=digits<=9", DIG2, DIG1, DIG0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        RESET = 1'b0; REVERSE = 1'b0; ENABLE = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!(UPD === 1'b1 && {DIG2, DIG1, DIG0} === 12'h457) && n < 2000);
        @(negedge CLK);
        total++;
        if ({DIG2, DIG1, DIG0, UPD} !== {12'h457, 1'b0}) begin
            bad++; $display("FAIL reach_457 got=%h exp=%h", {DIG2, DIG1, DIG0, UPD}, {12'h457, 1'b0});
        end
        #2 RESET = 1'b0;
        #1;
        total++;
        if ({DIG2, DIG1, DIG0, UPD, WRAP} !== 14'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=0000", {DIG2, DIG1, DIG0, UPD, WRAP});
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            total++;
            if ({DIG2, DIG1, DIG0, UPD, WRAP} !== {(c == 4) ? 12'h001 : 12'h000, (c == 4), 1'b0}) begin
                bad++; $display("FAIL restart c=%0d got=%h exp=%h", c, {DIG2, DIG1, DIG0, UPD, WRAP}, {(c == 4) ? 12'h001 : 12'h000, (c == 4), 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_enable_hold();
        test_reverse_pulse();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
